// File: rtl/integer_execute_pipe.sv
// Elastic RV32I ALU/branch execute pipe: compute in stage 0, DEPTH result stages, ROB-age flush.
// Optional multiplier enabled by defining INT_EXEC_MUL_EN.
module integer_execute_pipe #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst_aL,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     pc,
    input  logic [2:0]          funct3,
    input  logic                is_r_type,
    input  logic                is_i_type,
    input  logic                is_u_type,
    input  logic                is_b_type,
    input  logic                is_j_type,
    input  logic                is_sub,
    input  logic                is_sra_srai,
    input  logic                is_lui,
    input  logic                is_jalr,
    input  logic                is_mul,
    input  logic [ROB_ID_W-1:0] rob_id,
    input  logic                br_dir_pred,
    input  logic [ROB_ID_W-1:0] rob_head_id,
    input  logic                flush_valid,
    input  logic [ROB_ID_W-1:0] flush_rob_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROB_ID_W-1:0] out_rob_id,
    output logic                out_dst_valid,
    output logic [XLEN-1:0]     out_dst,
    output logic                out_br_wb_valid,
    output logic [XLEN-1:0]     out_npc,
    output logic                out_br_mispred,
    output logic [2:0]          occupancy
);

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic                dst_valid;
        logic [XLEN-1:0]     dst;
        logic                br_wb_valid;
        logic [XLEN-1:0]     npc;
        logic                mispred;
    } payload_t;

    logic [DEPTH-1:0] valid_q, valid_d, kill, adv;
    payload_t         pl_q [DEPTH];
    payload_t         pl_d [DEPTH];
    payload_t         st0;
    logic [XLEN-1:0]  op2, alu_res;
    logic [4:0]       shamt;
    logic             br_cond, taken, in_kill, adv_acc;
    logic [2:0]       occ;

    function automatic logic is_younger(input logic [ROB_ID_W-1:0] id,
                                        input logic [ROB_ID_W-1:0] head,
                                        input logic [ROB_ID_W-1:0] fl_id);
        logic [ROB_ID_W-1:0] age_id, age_fl;
        age_id = id - head;
        age_fl = fl_id - head;
        return age_id > age_fl;
    endfunction

    always_comb begin
        op2     = is_i_type ? imm : src2;
        shamt   = op2[4:0];
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = (is_r_type & is_sub) ? src1 - op2 : src1 + op2;
            3'b001:  alu_res = src1 << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(op2)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, src1 < op2};
            3'b100:  alu_res = src1 ^ op2;
            3'b101:  alu_res = is_sra_srai ? $unsigned($signed(src1) >>> shamt) : src1 >> shamt;
            3'b110:  alu_res = src1 | op2;
            default: alu_res = src1 & op2;
        endcase
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = src1 == src2;
            3'b001:  br_cond = src1 != src2;
            3'b100:  br_cond = $signed(src1) < $signed(src2);
            3'b101:  br_cond = $signed(src1) >= $signed(src2);
            3'b110:  br_cond = src1 < src2;
            3'b111:  br_cond = src1 >= src2;
            default: br_cond = 1'b0;
        endcase
        taken = is_b_type ? br_cond : (is_j_type | is_jalr);

        st0             = '0;
        st0.rob_id      = rob_id;
        st0.dst_valid   = ~is_b_type;
        st0.br_wb_valid = is_b_type | is_jalr;
        st0.mispred     = (br_dir_pred ^ taken) | is_jalr;
        st0.npc         = is_jalr ? ((src1 + imm) & {{(XLEN-1){1'b1}}, 1'b0}) : pc + imm;
        if (is_u_type)
            st0.dst = is_lui ? imm : pc + imm;
        else if (is_j_type | is_jalr)
            st0.dst = pc + XLEN'(4);
        else
            st0.dst = alu_res;
`ifndef INT_EXEC_MUL_EN
        // Without the multiplier an M op still retires, with a zero result.
        if (is_mul) begin
            st0.dst       = '0;
            st0.dst_valid = 1'b1;
        end
`endif
    end

`ifdef INT_EXEC_MUL_EN
    localparam int PW = 2 * XLEN;
    localparam int H  = XLEN / 2;

    logic          mul_q, mul_hi_q;
    logic [PW-1:0] pp_lo_q, pp_hi_q, pp_lo_d, pp_hi_d, prod;
    logic [XLEN:0] a_ext, b_ext;
    logic          sgn_a, sgn_b;

    if (DEPTH < 2) begin : g_depth_check
        $error("INT_EXEC_MUL_EN requires DEPTH >= 2");
    end

    // b is split into an unsigned low half and a signed high half; both rows are registered.
    always_comb begin
        sgn_a   = (funct3 == 3'b001) | (funct3 == 3'b010);
        sgn_b   = (funct3 == 3'b001);
        a_ext   = {sgn_a & src1[XLEN-1], src1};
        b_ext   = {sgn_b & src2[XLEN-1], src2};
        pp_lo_d = {{(PW-XLEN-1){a_ext[XLEN]}}, a_ext} * {{(PW-H){1'b0}}, b_ext[H-1:0]};
        pp_hi_d = {{(PW-XLEN-1){a_ext[XLEN]}}, a_ext} * {{(PW-(XLEN+1-H)){b_ext[XLEN]}}, b_ext[XLEN:H]};
        prod    = pp_lo_q + (pp_hi_q << H);
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            mul_q    <= 1'b0;
            mul_hi_q <= 1'b0;
            pp_lo_q  <= '0;
            pp_hi_q  <= '0;
        end else if (adv[0]) begin
            mul_q    <= is_mul & is_r_type;
            mul_hi_q <= funct3 != 3'b000;
            pp_lo_q  <= pp_lo_d;
            pp_hi_q  <= pp_hi_d;
        end
    end
`endif

    // Handshake: a stage advances when it or any stage after it is empty, or out_ready is high;
    // in_ready is stage 0's advance and is combinational from out_ready.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            adv_acc = out_ready;
            for (int j = k; j < DEPTH; j++) adv_acc = adv_acc | ~valid_q[j];
            adv[k]  = adv_acc;
            kill[k] = flush_valid & is_younger(pl_q[k].rob_id, rob_head_id, flush_rob_id);
        end
        in_kill    = flush_valid & is_younger(rob_id, rob_head_id, flush_rob_id);
        valid_d[0] = adv[0] ? (in_valid & ~in_kill) : (valid_q[0] & ~kill[0]);
        pl_d[0]    = st0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = adv[k] ? (valid_q[k-1] & ~kill[k-1]) : (valid_q[k] & ~kill[k]);
            pl_d[k]    = pl_q[k-1];
        end
`ifdef INT_EXEC_MUL_EN
        if (mul_q) pl_d[1].dst = mul_hi_q ? prod[PW-1:XLEN] : prod[XLEN-1:0];
`endif
        occ = '0;
        for (int k = 0; k < DEPTH; k++) occ = occ + {2'b00, valid_q[k]};
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) pl_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < DEPTH; k++)
                if (adv[k]) pl_q[k] <= pl_d[k];
        end
    end

    assign in_ready        = adv[0];
    assign out_valid       = valid_q[DEPTH-1] & ~kill[DEPTH-1];
    assign out_rob_id      = pl_q[DEPTH-1].rob_id;
    assign out_dst_valid   = pl_q[DEPTH-1].dst_valid;
    assign out_dst         = pl_q[DEPTH-1].dst;
    assign out_br_wb_valid = pl_q[DEPTH-1].br_wb_valid;
    assign out_npc         = pl_q[DEPTH-1].npc;
    assign out_br_mispred  = pl_q[DEPTH-1].mispred;
    assign occupancy       = occ;

endmodule

// File: tb/tb_integer_execute_pipe.sv
// Directed bench for integer_execute_pipe (DEPTH=2): vector table, backpressure, flush and reset sequences.
module tb_integer_execute_pipe;

    logic        clk = 1'b0;
    logic        rst_aL;
    logic        in_valid, in_ready;
    logic [31:0] src1, src2, imm, pc;
    logic [2:0]  funct3;
    logic        is_r_type, is_i_type, is_u_type, is_b_type, is_j_type;
    logic        is_sub, is_sra_srai, is_lui, is_jalr, is_mul;
    logic [3:0]  rob_id, rob_head_id, flush_rob_id, out_rob_id;
    logic        br_dir_pred, flush_valid;
    logic        out_valid, out_ready, out_dst_valid, out_br_wb_valid, out_br_mispred;
    logic [31:0] out_dst, out_npc;
    logic [2:0]  occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    integer_execute_pipe #(.XLEN(32), .DEPTH(2), .ROB_ID_W(4)) dut (
        .clk(clk), .rst_aL(rst_aL), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .imm(imm), .pc(pc), .funct3(funct3),
        .is_r_type(is_r_type), .is_i_type(is_i_type), .is_u_type(is_u_type),
        .is_b_type(is_b_type), .is_j_type(is_j_type), .is_sub(is_sub),
        .is_sra_srai(is_sra_srai), .is_lui(is_lui), .is_jalr(is_jalr), .is_mul(is_mul),
        .rob_id(rob_id), .br_dir_pred(br_dir_pred), .rob_head_id(rob_head_id),
        .flush_valid(flush_valid), .flush_rob_id(flush_rob_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_id(out_rob_id),
        .out_dst_valid(out_dst_valid), .out_dst(out_dst), .out_br_wb_valid(out_br_wb_valid),
        .out_npc(out_npc), .out_br_mispred(out_br_mispred), .occupancy(occupancy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [4:0] FR = 5'b10000, FI = 5'b01000, FU = 5'b00100, FB = 5'b00010, FJ = 5'b00001;
    localparam logic [4:0] QSUB = 5'b10000, QSRA = 5'b01000, QLUI = 5'b00100, QJALR = 5'b00010, QMUL = 5'b00001;
`ifdef INT_EXEC_MUL_EN
    localparam logic [31:0] MULHU_EXP = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] MULHU_EXP = 32'h0;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  fmt;
        logic [4:0]  qual;
        logic [31:0] s1, s2, im, p;
        logic        pred;
        logic [31:0] e_dst;
        logic        e_dv, e_bwb;
        logic [31:0] e_npc;
        logic        e_mp;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    logic [35:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_op();
        in_valid = 1'b0;
        src1 = '0; src2 = '0; imm = '0; pc = '0; funct3 = '0; rob_id = '0; br_dir_pred = 1'b0;
        {is_r_type, is_i_type, is_u_type, is_b_type, is_j_type} = '0;
        {is_sub, is_sra_srai, is_lui, is_jalr, is_mul} = '0;
    endtask

    task automatic drive_vec(input vec_t v, input logic [3:0] id);
        funct3 = v.f3;
        {is_r_type, is_i_type, is_u_type, is_b_type, is_j_type} = v.fmt;
        {is_sub, is_sra_srai, is_lui, is_jalr, is_mul} = v.qual;
        src1 = v.s1; src2 = v.s2; imm = v.im; pc = v.p; br_dir_pred = v.pred;
        rob_id = id;
        in_valid = 1'b1;
    endtask

    task automatic drive_addi(input logic [3:0] id, input logic [31:0] a, input logic [31:0] b);
        clr_op();
        is_i_type = 1'b1; src1 = a; imm = b; rob_id = id; in_valid = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{3'b000, FI, 5'b0,  32'd5,         32'd0,         32'hFFFF_FFF9, 32'h0,     1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0,     1'b0};
        vecs[1]  = '{3'b000, FR, QSUB,  32'd10,        32'd3,         32'h0,         32'h0,     1'b0, 32'd7,         1'b1, 1'b0, 32'h0,     1'b0};
        vecs[2]  = '{3'b001, FR, 5'b0,  32'd1,         32'h3F,        32'h0,         32'h0,     1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h0,     1'b0};
        vecs[3]  = '{3'b010, FR, 5'b0,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'h0,     1'b0, 32'd1,         1'b1, 1'b0, 32'h0,     1'b0};
        vecs[4]  = '{3'b011, FR, 5'b0,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'h0,     1'b0, 32'd0,         1'b1, 1'b0, 32'h0,     1'b0};
        vecs[5]  = '{3'b100, FI, 5'b0,  32'hF0F0_F0F0, 32'h0,         32'hFFFF_FFFF, 32'h0,     1'b0, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h0,     1'b0};
        vecs[6]  = '{3'b101, FI, QSRA,  32'h8000_0000, 32'h0,         32'h404,       32'h0,     1'b0, 32'hF800_0000, 1'b1, 1'b0, 32'h0,     1'b0};
        vecs[7]  = '{3'b101, FR, 5'b0,  32'h8000_0000, 32'd4,         32'h0,         32'h0,     1'b0, 32'h0800_0000, 1'b1, 1'b0, 32'h0,     1'b0};
        vecs[8]  = '{3'b110, FR, 5'b0,  32'h0F00,      32'h00F0,      32'h0,         32'h0,     1'b0, 32'h0FF0,      1'b1, 1'b0, 32'h0,     1'b0};
        vecs[9]  = '{3'b111, FI, 5'b0,  32'h1234_5678, 32'h0,         32'h0000_FF00, 32'h0,     1'b0, 32'h0000_5600, 1'b1, 1'b0, 32'h0,     1'b0};
        vecs[10] = '{3'b000, FU, QLUI,  32'h0,         32'h0,         32'hABCD_E000, 32'h0,     1'b0, 32'hABCD_E000, 1'b1, 1'b0, 32'h0,     1'b0};
        vecs[11] = '{3'b000, FU, 5'b0,  32'h0,         32'h0,         32'h2000,      32'h1000,  1'b0, 32'h3000,      1'b1, 1'b0, 32'h0,     1'b0};
        vecs[12] = '{3'b000, FJ, 5'b0,  32'h0,         32'h0,         32'h40,        32'h200,   1'b1, 32'h204,       1'b1, 1'b0, 32'h240,   1'b0};
        vecs[13] = '{3'b000, FI, QJALR, 32'h1001,      32'h0,         32'h6,         32'h300,   1'b0, 32'h304,       1'b1, 1'b1, 32'h1006,  1'b1};
        vecs[14] = '{3'b000, FB, 5'b0,  32'd3,         32'd3,         32'h20,        32'h100,   1'b0, 32'h0,         1'b0, 1'b1, 32'h120,   1'b1};
        vecs[15] = '{3'b001, FB, 5'b0,  32'd3,         32'd3,         32'h20,        32'h100,   1'b0, 32'h0,         1'b0, 1'b1, 32'h120,   1'b0};
        vecs[16] = '{3'b100, FB, 5'b0,  32'hFFFF_FFFF, 32'd1,         32'h8,         32'h400,   1'b1, 32'h0,         1'b0, 1'b1, 32'h408,   1'b0};
        vecs[17] = '{3'b111, FB, 5'b0,  32'hFFFF_FFFF, 32'd1,         32'h10,        32'h500,   1'b0, 32'h0,         1'b0, 1'b1, 32'h510,   1'b1};
        vecs[18] = '{3'b110, FB, 5'b0,  32'hFFFF_FFFF, 32'd1,         32'hC,         32'h600,   1'b1, 32'h0,         1'b0, 1'b1, 32'h60C,   1'b1};
        vecs[19] = '{3'b101, FB, 5'b0,  32'd5,         32'd5,         32'hFFFF_FFF0, 32'h700,   1'b1, 32'h0,         1'b0, 1'b1, 32'h6F0,   1'b0};
        vecs[20] = '{3'b011, FR, QMUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,     1'b0, MULHU_EXP,     1'b1, 1'b0, 32'h0,     1'b0};

        // reset
        rst_aL = 1'b0; out_ready = 1'b1; flush_valid = 1'b0; flush_rob_id = '0; rob_head_id = '0;
        clr_op();
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_occupancy", {29'b0, occupancy}, 32'd0);
        chk("rst_out_dst", out_dst, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_aL = 1'b1;
        tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // vector table, one op at a time
        for (int i = 0; i < NV; i++) begin
            drive_vec(vecs[i], 4'(i));
            tick();
            chk($sformatf("v%0d_latency", i), {31'b0, out_valid}, 32'd0);
            clr_op();
            tick();
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_rob_id", i), {28'b0, out_rob_id}, {28'b0, 4'(i)});
            chk($sformatf("v%0d_dst_valid", i), {31'b0, out_dst_valid}, {31'b0, vecs[i].e_dv});
            chk($sformatf("v%0d_br_wb_valid", i), {31'b0, out_br_wb_valid}, {31'b0, vecs[i].e_bwb});
            if (vecs[i].e_dv) chk($sformatf("v%0d_dst", i), out_dst, vecs[i].e_dst);
            if (vecs[i].e_bwb || vecs[i].fmt == FJ) chk($sformatf("v%0d_npc", i), out_npc, vecs[i].e_npc);
            if (vecs[i].e_bwb) chk($sformatf("v%0d_mispred", i), {31'b0, out_br_mispred}, {31'b0, vecs[i].e_mp});
            tick();
            chk($sformatf("v%0d_drained", i), {29'b0, occupancy}, 32'd0);
        end

        // back-to-back stream with a 4-cycle output stall
        begin
            int sent = 0;
            int got = 0;
            logic [35:0] e;
            logic [31:0] hold_dst = '0;
            logic hold_set = 1'b0;
            for (int c = 0; c < 40 && got < 8; c++) begin
                out_ready = !(c >= 3 && c <= 6);
                if (sent < 8) drive_addi(4'(sent), 32'(sent * 100), 32'(sent));
                else clr_op();
                #1;
                if (c >= 3 && c <= 6) begin
                    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    chk("stall_occupancy", {29'b0, occupancy}, 32'd2);
                    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
                    if (hold_set) chk("stall_dst_stable", out_dst, hold_dst);
                    else begin hold_dst = out_dst; hold_set = 1'b1; end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("b2b_extra_output", {28'b0, out_rob_id}, 32'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("b2b_rob_id", {28'b0, out_rob_id}, {28'b0, e[35:32]});
                        chk("b2b_dst", out_dst, e[31:0]);
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({4'(sent), 32'(sent * 101)});
                    sent++;
                end
                @(posedge clk);
                #1;
            end
            chk("b2b_count", 32'(got), 32'd8);
            chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
            clr_op();
            out_ready = 1'b1;
            tick();
        end

        // flush: head 14, flush point 15; 15 survives, 0/1/2 are killed or dropped
        rob_head_id = 4'd14;
        out_ready = 1'b0;
        drive_addi(4'd15, 32'd1, 32'd1); tick();
        drive_addi(4'd0, 32'd2, 32'd2); tick();
        chk("flush_pre_occupancy", {29'b0, occupancy}, 32'd2);
        out_ready = 1'b1; flush_valid = 1'b1; flush_rob_id = 4'd15;
        drive_addi(4'd1, 32'd3, 32'd3);
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_survivor_valid", {31'b0, out_valid}, 32'd1);
        chk("flush_survivor_id", {28'b0, out_rob_id}, 32'd15);
        chk("flush_survivor_dst", out_dst, 32'd2);
        tick();
        chk("flush_post_occupancy", {29'b0, occupancy}, 32'd0);
        drive_addi(4'd2, 32'd4, 32'd4);
        #1;
        chk("flush_id2_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("flush_id2_dropped", {29'b0, occupancy}, 32'd0);
        flush_valid = 1'b0;
        clr_op();
        for (int c = 0; c < 3; c++) begin
            chk("flush_no_output", {31'b0, out_valid}, 32'd0);
            tick();
        end

        // flush masks a killed op sitting in the last stage
        out_ready = 1'b0;
        drive_addi(4'd0, 32'd7, 32'd7); tick();
        drive_addi(4'd1, 32'd8, 32'd8); tick();
        clr_op();
        flush_valid = 1'b1; flush_rob_id = 4'd15;
        #1;
        chk("kill_mask_out_valid", {31'b0, out_valid}, 32'd0);
        chk("kill_mask_occupancy", {29'b0, occupancy}, 32'd2);
        tick();
        chk("kill_cleared_occupancy", {29'b0, occupancy}, 32'd0);
        flush_valid = 1'b0; rob_head_id = '0; out_ready = 1'b1;
        tick();

        // asynchronous reset with a full pipe
        out_ready = 1'b0;
        drive_addi(4'd3, 32'd9, 32'd9); tick();
        drive_addi(4'd4, 32'd10, 32'd10); tick();
        clr_op();
        #1;
        chk("prerst_occupancy", {29'b0, occupancy}, 32'd2);
        chk("prerst_out_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_aL = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_occupancy", {29'b0, occupancy}, 32'd0);
        chk("midrst_out_dst", out_dst, 32'd0);
        @(posedge clk);
        #3 rst_aL = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("postrst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
